// File: rtl/vote_pkg.sv
// Shared types and helpers for the vote tally block.
package vote_pkg;

   typedef enum logic [1:0] {IDLE, OPEN, DONE} vote_state_t;

   // Bits needed to hold a count from 0 to n inclusive.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/popcount.sv
// Combinational one-count of a W-bit vector.
module popcount
   import vote_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0]          vec_i,
   output logic [cnt_w(W)-1:0]   cnt_o
);

   localparam int CW = cnt_w(W);

   always_comb begin
      cnt_o = '0;
      for (int i = 0; i < W; i++) begin
         cnt_o = cnt_o + CW'(vec_i[i]);
      end
   end

endmodule

// File: rtl/vote_tally.sv
// Voting session controller: one vote per voter, popcount tally, and held
// result flags after close by all-voted, explicit close or timeout.
module vote_tally
   import vote_pkg::*;
#(
   parameter int N_VOTERS = 4,
   parameter int THRESH   = N_VOTERS / 2 + 1,
   parameter int TIMEOUT  = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         close,
   input  logic [N_VOTERS-1:0]          vote_valid,
   input  logic [N_VOTERS-1:0]          vote_val,
   output logic                         busy,
   output logic                         done,
   output logic [cnt_w(N_VOTERS)-1:0]   yes_cnt,
   output logic [cnt_w(N_VOTERS)-1:0]   no_cnt,
   output logic                         majority,
   output logic                         pass,
   output logic                         tie,
   output logic                         timed_out
);

   localparam int CW = cnt_w(N_VOTERS);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   vote_state_t          state_q;
   logic [N_VOTERS-1:0]  voted_q, voted_d;
   logic [N_VOTERS-1:0]  accepted, yes_vec, no_vec;
   logic [CW-1:0]        yes_q, yes_d, no_q, no_d, yes_add, no_add;
   logic [TW-1:0]        timer_q;
   logic                 timed_out_q;
   logic                 all_voted, time_hit;

   // Only first votes in an open session reach the counters.
   assign accepted = (state_q == OPEN) ? (vote_valid & ~voted_q) : '0;
   assign yes_vec  = accepted & vote_val;
   assign no_vec   = accepted & ~vote_val;

   popcount #(.W(N_VOTERS)) u_pc_yes (.vec_i(yes_vec), .cnt_o(yes_add));
   popcount #(.W(N_VOTERS)) u_pc_no  (.vec_i(no_vec),  .cnt_o(no_add));

   assign voted_d   = voted_q | accepted;
   assign yes_d     = yes_q + yes_add;
   assign no_d      = no_q + no_add;
   assign all_voted = &voted_d;
   assign time_hit  = (TIMEOUT != 0) && (timer_q == TLAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         voted_q     <= '0;
         yes_q       <= '0;
         no_q        <= '0;
         timer_q     <= '0;
         timed_out_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q     <= OPEN;
                  voted_q     <= '0;
                  yes_q       <= '0;
                  no_q        <= '0;
                  timer_q     <= '0;
                  timed_out_q <= 1'b0;
               end
            end
            OPEN: begin
               voted_q <= voted_d;
               yes_q   <= yes_d;
               no_q    <= no_d;
               timer_q <= timer_q + 1'b1;
               // Exit-cycle votes are already folded into the _d values.
               if (all_voted || close) begin
                  state_q <= DONE;
               end else if (time_hit) begin
                  state_q     <= DONE;
                  timed_out_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = (state_q == OPEN);
   assign done      = (state_q == DONE);
   assign yes_cnt   = yes_q;
   assign no_cnt    = no_q;
   assign timed_out = timed_out_q;
   assign majority  = done && (yes_q > no_q);
   assign pass      = done && (int'(yes_q) >= THRESH);
   assign tie       = done && (yes_q == no_q);

endmodule

// File: tb/tb_vote_tally.sv
// Randomized and directed scoreboard bench for vote_tally (4 voters,
// threshold 3, timeout 16).
module tb_vote_tally;

   localparam int N  = 4;
   localparam int TH = 3;
   localparam int TO = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         start, close;
   logic [N-1:0] vote_valid, vote_val;
   logic         busy, done, majority, pass, tie, timed_out;
   logic [2:0]   yes_cnt, no_cnt;

   vote_tally #(.N_VOTERS(N), .THRESH(TH), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .close(close),
      .vote_valid(vote_valid), .vote_val(vote_val),
      .busy(busy), .done(done), .yes_cnt(yes_cnt), .no_cnt(no_cnt),
      .majority(majority), .pass(pass), .tie(tie), .timed_out(timed_out)
   );

   always #5 clk = ~clk;

   typedef struct {int yes; int no; bit maj; bit pss; bit tie; bit to;} exp_t;
   exp_t q[$];

   int total = 0;
   int bad   = 0;

   // Reference model: session status plus per-voter "has voted" flags.
   bit m_open, m_done, m_to;
   bit m_voted[N];
   int m_yes, m_no, m_t;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive at negedge, advance model at posedge, check at negedge.
   task automatic cyc(input bit st, input logic [N-1:0] vv,
                      input logic [N-1:0] vl, input bit cl);
      bit all, fin;
      exp_t e;
      start = st; vote_valid = vv; vote_val = vl; close = cl;
      @(posedge clk);
      if (!m_open) begin
         if (st) begin
            m_open = 1; m_done = 0; m_to = 0; m_yes = 0; m_no = 0; m_t = 0;
            for (int i = 0; i < N; i++) m_voted[i] = 0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (vv[i] && !m_voted[i]) begin
               m_voted[i] = 1;
               if (vl[i]) m_yes++; else m_no++;
            end
         end
         all = 1;
         for (int i = 0; i < N; i++) all &= m_voted[i];
         fin = all || cl;
         if (!fin && m_t == TO - 1) begin fin = 1; m_to = 1; end
         m_t++;
         if (fin) begin
            m_open = 0; m_done = 1;
            e.yes = m_yes; e.no = m_no; e.to = m_to;
            e.maj = m_yes > m_no; e.pss = m_yes >= TH; e.tie = m_yes == m_no;
            q.push_back(e);
         end
      end
      @(negedge clk);
      chk("busy", busy, m_open);
      chk("done", done, m_done);
      chk("yes_cnt", int'(yes_cnt), m_yes);
      chk("no_cnt", int'(no_cnt), m_no);
      chk("timed_out", timed_out, m_to);
      if (!m_done) chk("flags_gated", {majority, pass, tie}, 0);
   endtask

   task automatic do_reset();
      rst = 1;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_counts", {yes_cnt, no_cnt}, 0);
      chk("rst_flags", {majority, pass, tie, timed_out}, 0);
      m_open = 0; m_done = 0; m_to = 0; m_yes = 0; m_no = 0; m_t = 0;
      start = 0; close = 0; vote_valid = '0; vote_val = '0;
      @(negedge clk);
      rst = 0;
   endtask

   // Monitor: each rising done is checked against the next queued result.
   initial begin
      bit prev;
      exp_t e;
      prev = 0;
      forever begin
         @(negedge clk);
         if (!rst && done && !prev) begin
            if (q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_done: got done=1 want no pending result");
            end else begin
               e = q.pop_front();
               chk("sb_yes", int'(yes_cnt), e.yes);
               chk("sb_no", int'(no_cnt), e.no);
               chk("sb_majority", majority, e.maj);
               chk("sb_pass", pass, e.pss);
               chk("sb_tie", tie, e.tie);
               chk("sb_timed_out", timed_out, e.to);
            end
         end
         prev = done;
      end
   end

   initial begin
      int n;
      rst = 1; start = 0; close = 0; vote_valid = '0; vote_val = '0;
      @(negedge clk);
      do_reset();

      // All vote at once, 3 yes 1 no; then restart from DONE with a stray vote.
      cyc(1, 4'b0000, 4'b0000, 0);
      cyc(0, 4'b1111, 4'b1011, 0);
      cyc(1, 4'b0001, 4'b0001, 0);
      cyc(0, 4'b0000, 4'b0000, 1);

      // Separate votes with a repeat from voter 0.
      cyc(1, 4'b0000, 4'b0000, 0);
      cyc(0, 4'b0001, 4'b0001, 0);
      cyc(0, 4'b0010, 4'b0010, 0);
      cyc(0, 4'b0100, 4'b0000, 0);
      cyc(0, 4'b0001, 4'b0000, 0);
      cyc(0, 4'b1000, 4'b0000, 0);

      // Timeout after exactly TO edges.
      cyc(1, 4'b0000, 4'b0000, 0);
      cyc(0, 4'b0001, 4'b0001, 0);
      n = 1;
      while (m_open && n < 40) begin cyc(0, 4'b0000, 4'b0000, 0); n++; end
      chk("timeout_edges", n, TO);

      // Close together with a third yes vote.
      cyc(1, 4'b0000, 4'b0000, 0);
      cyc(0, 4'b0001, 4'b0001, 0);
      cyc(0, 4'b0010, 4'b0010, 0);
      cyc(0, 4'b0100, 4'b0100, 1);

      // Reset mid-session, then a fresh session from zero.
      cyc(1, 4'b0000, 4'b0000, 0);
      cyc(0, 4'b0011, 4'b0011, 0);
      do_reset();
      cyc(1, 4'b1111, 4'b1111, 0);
      cyc(0, 4'b0000, 4'b0000, 1);

      // Random sessions.
      for (int s = 0; s < 60; s++) begin
         cyc(1, 4'($urandom), 4'($urandom), $urandom_range(0, 3) == 0);
         for (int k = 0; k < 40 && m_open; k++) begin
            if ($urandom_range(0, 40) == 0) begin
               do_reset();
               break;
            end
            cyc($urandom_range(0, 7) == 0, 4'($urandom & $urandom),
                4'($urandom), $urandom_range(0, 15) == 0);
         end
         for (int k = $urandom_range(0, 3); k > 0; k--)
            cyc(0, 4'($urandom), 4'($urandom), $urandom_range(0, 1) == 1);
      end

      cyc(0, 4'b0000, 4'b0000, 0);
      cyc(0, 4'b0000, 4'b0000, 0);
      chk("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
